// File: rtl/morse_pkg.sv
// Shared constants, register map and the Morse-to-ASCII lookup.
package morse_pkg;

    localparam logic DOT  = 1'b0;
    localparam logic DASH = 1'b1;

    localparam logic [7:0] CHAR_INVALID = 8'h23;

    typedef enum logic [1:0] {
        REG_STATUS = 2'd0,
        REG_DATA   = 2'd1,
        REG_CTRL   = 2'd2,
        REG_LEVEL  = 2'd3
    } reg_addr_e;

    localparam int CTRL_FLUSH    = 0;
    localparam int CTRL_CLR_ERR  = 1;
    localparam int CTRL_AUTO_GAP = 2;

    // Key is {length, symbols}; symbol i sits at bit i, unused bits forced to 0.
    function automatic logic [7:0] morse_lookup(input logic [2:0] len, input logic [6:0] pattern);
        logic [4:0] p;
        logic [7:0] c;
        p = '0;
        for (int i = 0; i < 5; i++) begin
            if (i < int'(len)) p[i] = pattern[i];
        end
        case ({len, p})
            {3'd1, 5'b00000}: c = 8'h45; // E
            {3'd1, 5'b00001}: c = 8'h54; // T
            {3'd2, 5'b00010}: c = 8'h41; // A
            {3'd2, 5'b00000}: c = 8'h49; // I
            {3'd2, 5'b00011}: c = 8'h4D; // M
            {3'd2, 5'b00001}: c = 8'h4E; // N
            {3'd3, 5'b00001}: c = 8'h44; // D
            {3'd3, 5'b00011}: c = 8'h47; // G
            {3'd3, 5'b00101}: c = 8'h4B; // K
            {3'd3, 5'b00111}: c = 8'h4F; // O
            {3'd3, 5'b00010}: c = 8'h52; // R
            {3'd3, 5'b00000}: c = 8'h53; // S
            {3'd3, 5'b00100}: c = 8'h55; // U
            {3'd3, 5'b00110}: c = 8'h57; // W
            {3'd4, 5'b00001}: c = 8'h42; // B
            {3'd4, 5'b00101}: c = 8'h43; // C
            {3'd4, 5'b00100}: c = 8'h46; // F
            {3'd4, 5'b00000}: c = 8'h48; // H
            {3'd4, 5'b01110}: c = 8'h4A; // J
            {3'd4, 5'b00010}: c = 8'h4C; // L
            {3'd4, 5'b00110}: c = 8'h50; // P
            {3'd4, 5'b01011}: c = 8'h51; // Q
            {3'd4, 5'b01000}: c = 8'h56; // V
            {3'd4, 5'b01001}: c = 8'h58; // X
            {3'd4, 5'b01101}: c = 8'h59; // Y
            {3'd4, 5'b00011}: c = 8'h5A; // Z
            {3'd5, 5'b11111}: c = 8'h30;
            {3'd5, 5'b11110}: c = 8'h31;
            {3'd5, 5'b11100}: c = 8'h32;
            {3'd5, 5'b11000}: c = 8'h33;
            {3'd5, 5'b10000}: c = 8'h34;
            {3'd5, 5'b00000}: c = 8'h35;
            {3'd5, 5'b00001}: c = 8'h36;
            {3'd5, 5'b00011}: c = 8'h37;
            {3'd5, 5'b00111}: c = 8'h38;
            {3'd5, 5'b01111}: c = 8'h39;
            default:          c = CHAR_INVALID;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/morse_decoder_fifo_input_cond.sv
// Two-flop synchroniser, counting debouncer and rising-edge pulse for one input.
module morse_input_cond #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_a, sync_b;
    logic          level, level_q;
    logic [CW-1:0] cnt;

    // Synchronise, then accept a new level only after it differs for DEBOUNCE_CYCLES samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a  <= 1'b0;
            sync_b  <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            cnt     <= '0;
        end else begin
            sync_a  <= din;
            sync_b  <= sync_a;
            level_q <= level;
            if (sync_b == level) begin
                cnt <= CNT_LOAD;
            end else if (cnt == '0) begin
                level <= sync_b;
                cnt   <= CNT_LOAD;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign pulse = level & ~level_q;

endmodule

// File: rtl/morse_decoder_fifo.sv
// Morse decoder: conditioned dot/dash/done inputs, symbol assembly, decode, byte FIFO, register slave.
module morse_decoder_fifo
    import morse_pkg::*;
#(
    parameter int DEPTH           = 16,
    parameter int MAX_SYMBOLS     = 5,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int GAP_CYCLES      = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] address,
    input  logic       read,
    output logic [7:0] read_data,
    input  logic       write,
    input  logic [7:0] write_data,
    input  logic [1:0] button_in,
    input  logic [3:0] switch_in
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int GW = $clog2(GAP_CYCLES + 1);

    logic dot_p, dash_p, done_p;

    morse_input_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dot  (.clk(clk), .rst(rst), .din(button_in[0]), .pulse(dot_p));
    morse_input_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dash (.clk(clk), .rst(rst), .din(button_in[1]), .pulse(dash_p));
    morse_input_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_done (.clk(clk), .rst(rst), .din(switch_in[0]), .pulse(done_p));

    logic unused_bits;
    assign unused_bits = ^{switch_in[3:1], write_data[7:3]};

    logic [MAX_SYMBOLS-1:0] sym_buf, buf_eff;
    logic [2:0]             sym_cnt, cnt_eff;
    logic                   too_long, sym_err, ovf, auto_gap;
    logic [GW-1:0]          gap_cnt;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;

    logic sym_one, sym_both, append, sym_dropped;
    logic gap_active, gap_expire, complete, push, push_ok, push_drop, pop;
    logic ctrl_wr, flush, clr_err, empty, full;
    logic [7:0] push_byte;

    assign sym_one     = dot_p ^ dash_p;
    assign sym_both    = dot_p & dash_p;
    assign append      = sym_one && (sym_cnt < 3'(MAX_SYMBOLS));
    assign sym_dropped = sym_one && !append;
    assign gap_active  = auto_gap && (sym_cnt != 3'd0);
    assign gap_expire  = gap_active && (gap_cnt == GW'(GAP_CYCLES - 1));
    assign complete    = done_p || gap_expire;

    assign ctrl_wr = write && (reg_addr_e'(address) == REG_CTRL);
    assign flush   = ctrl_wr && write_data[CTRL_FLUSH];
    assign clr_err = ctrl_wr && write_data[CTRL_CLR_ERR];

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign pop       = read && (reg_addr_e'(address) == REG_DATA) && !empty;
    assign push      = complete && (cnt_eff != 3'd0);
    assign push_ok   = push && (!full || pop) && !flush;
    assign push_drop = push && full && !pop && !flush;

    // A symbol arriving with the completion is folded in before decoding.
    always_comb begin
        buf_eff = sym_buf;
        cnt_eff = sym_cnt;
        if (append) begin
            buf_eff[sym_cnt] = dash_p;
            cnt_eff          = sym_cnt + 3'd1;
        end
        push_byte = (too_long || sym_dropped) ? CHAR_INVALID : morse_lookup(cnt_eff, 7'(buf_eff));
    end

    // Symbol buffer, length and too-long flag.
    always_ff @(posedge clk) begin
        if (rst || flush || complete) begin
            sym_buf  <= '0;
            sym_cnt  <= 3'd0;
            too_long <= 1'b0;
        end else begin
            if (append) begin
                sym_buf[sym_cnt] <= dash_p;
                sym_cnt          <= sym_cnt + 3'd1;
            end
            if (sym_dropped) too_long <= 1'b1;
        end
    end

    // Inter-character gap timer: counts up while armed, restarts on each symbol.
    always_ff @(posedge clk) begin
        if (rst || flush || append || complete || !auto_gap) begin
            gap_cnt <= '0;
        end else if (gap_active && gap_cnt != GW'(GAP_CYCLES - 1)) begin
            gap_cnt <= gap_cnt + 1'b1;
        end
    end

    // Sticky error flags and persistent control bit; a new error beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            sym_err  <= 1'b0;
            ovf      <= 1'b0;
            auto_gap <= 1'b0;
        end else begin
            if (clr_err) begin
                sym_err <= 1'b0;
                ovf     <= 1'b0;
            end
            if (sym_both)  sym_err <= 1'b1;
            if (push_drop) ovf     <= 1'b1;
            if (ctrl_wr)   auto_gap <= write_data[CTRL_AUTO_GAP];
        end
    end

    // FIFO pointers and occupancy; flush wins over any push.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; contents are don't-care while empty so no reset.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_byte;
    end

    // Combinational register read mux.
    always_comb begin
        read_data = 8'h00;
        case (reg_addr_e'(address))
            REG_STATUS: read_data = {1'b0, sym_cnt, sym_err, ovf, full, !empty};
            REG_DATA:   read_data = empty ? 8'h00 : mem[rd_ptr];
            REG_CTRL:   read_data[CTRL_AUTO_GAP] = auto_gap;
            REG_LEVEL:  read_data = 8'(count);
            default:    read_data = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_morse_decoder_fifo.sv
// Directed bench: stimulus pushes expected characters, a forked monitor checks every DATA pop.
module tb_morse_decoder_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] address;
    logic       read;
    logic [7:0] read_data;
    logic       write;
    logic [7:0] write_data;
    logic [1:0] button_in;
    logic [3:0] switch_in;

    int checks = 0;
    int errors = 0;
    logic [7:0] sb[$];

    morse_decoder_fifo #(
        .DEPTH(4), .MAX_SYMBOLS(5), .DEBOUNCE_CYCLES(4), .GAP_CYCLES(32)
    ) dut (
        .clk(clk), .rst(rst), .address(address), .read(read), .read_data(read_data),
        .write(write), .write_data(write_data), .button_in(button_in), .switch_in(switch_in)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic peek(input logic [1:0] a, input logic [7:0] exp, input string name);
        @(negedge clk);
        address = a;
        #1 check(name, read_data, exp);
    endtask

    task automatic reg_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        address    = a;
        write_data = d;
        write      = 1'b1;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic pop_data();
        @(negedge clk);
        address = 2'd1;
        read    = 1'b1;
        @(negedge clk);
        read = 1'b0;
    endtask

    task automatic press(input logic [1:0] b);
        @(negedge clk);
        button_in = b;
        repeat (10) @(negedge clk);
        button_in = 2'b00;
        repeat (10) @(negedge clk);
    endtask

    task automatic press_done();
        @(negedge clk);
        switch_in = 4'b0001;
        repeat (10) @(negedge clk);
        switch_in = 4'b0000;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; address = 2'd0; read = 1'b0; write = 1'b0;
        write_data = 8'h00; button_in = 2'b00; switch_in = 4'b0000;

        fork
            forever begin
                @(negedge clk);
                #2;
                if (read && address == 2'd1) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL data_unexpected: got 0x%02h, expected no pop", read_data);
                    end else begin
                        check("data_pop", read_data, sb.pop_front());
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        rst = 1'b0;
        peek(2'd0, 8'h00, "rst_status");
        peek(2'd1, 8'h00, "rst_data");
        peek(2'd2, 8'h00, "rst_ctrl");
        peek(2'd3, 8'h00, "rst_level");

        // A = dot dash
        press(2'b01); press(2'b10);
        peek(2'd0, 8'h20, "a_symcnt");
        press_done(); sb.push_back(8'h41);
        peek(2'd0, 8'h01, "a_status");
        peek(2'd3, 8'h01, "a_level");
        pop_data();
        peek(2'd3, 8'h00, "a_level_after");
        peek(2'd0, 8'h00, "a_status_after");
        peek(2'd1, 8'h00, "empty_data");

        // 0 = five dashes
        repeat (5) press(2'b10);
        press_done(); sb.push_back(8'h30);
        pop_data();

        // six symbols -> '#'
        repeat (6) press(2'b01);
        peek(2'd0, 8'h50, "long_symcnt");
        press_done(); sb.push_back(8'h23);
        pop_data();
        peek(2'd0, 8'h00, "long_cleared");

        // overflow with five E
        for (int i = 0; i < 5; i++) begin
            press(2'b01);
            press_done();
            if (i < 4) sb.push_back(8'h45);
        end
        peek(2'd3, 8'h04, "ovf_level");
        peek(2'd0, 8'h07, "ovf_status");
        reg_write(2'd2, 8'h02);
        peek(2'd0, 8'h03, "clr_err_status");
        repeat (4) pop_data();
        peek(2'd0, 8'h00, "drained_status");

        // auto gap completes 'T'
        reg_write(2'd2, 8'h04);
        peek(2'd2, 8'h04, "ctrl_auto");
        press(2'b10);
        peek(2'd3, 8'h00, "gap_not_yet");
        sb.push_back(8'h54);
        repeat (40) @(negedge clk);
        peek(2'd3, 8'h01, "gap_level");
        pop_data();

        // no auto gap: dot stays pending, flush clears it
        reg_write(2'd2, 8'h00);
        press(2'b01);
        repeat (100) @(negedge clk);
        peek(2'd3, 8'h00, "nogap_level");
        peek(2'd0, 8'h10, "nogap_status");
        reg_write(2'd2, 8'h01);
        peek(2'd0, 8'h00, "flush_status");
        peek(2'd2, 8'h00, "flush_ctrl");

        // simultaneous dot and dash
        press(2'b11);
        peek(2'd0, 8'h08, "both_status");
        reg_write(2'd2, 8'h02);
        peek(2'd0, 8'h00, "both_cleared");

        // reset mid-character
        press(2'b01); press(2'b01);
        peek(2'd0, 8'h20, "pre_rst_status");
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        peek(2'd0, 8'h00, "post_rst_status");
        peek(2'd3, 8'h00, "post_rst_level");
        press_done();
        peek(2'd3, 8'h00, "post_rst_done_level");
        peek(2'd0, 8'h00, "post_rst_done_status");

        repeat (3) @(negedge clk);
        check("sb_drained", 8'(sb.size()), 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
